period_meter: RTL and testbench

- Measures the period of a slow, asynchronous square wave (a divided clock or a sampled entropy-source oscillator) in units of clk_in cycles. It performs the inverse of the divider: clk_out from a divider with Divider=N reads back as 2*(N+1).
- Sits between slow-clock sources and the TRNG health and calibration logic. It delivers one period word per rising edge over a valid/ready handshake.

---
 rtl/period_meter.sv | 122 ++++++++++++
 tb/tb_period_meter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures the period of a slow asynchronous square wave in
// clk_in cycles and hands each result out over a valid/ready register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | disabled; counter held at zero
//   ARM     | enabled; waiting for the first rising edge to start timing
//   MEASURE | counting cycles between consecutive rising edges
module period_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PERIOD  = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             ovf,
    output logic             glitch,
    output logic             dropped,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   sync_out;
    logic                   rise;
    logic                   capture;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_d;
    // The enable fall wins over a coincident rise, so capture needs enable.
    assign capture  = (state == MEASURE) & rise & enable;

    // Synchronizer chain plus edge-detect register; runs regardless of enable.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_d <= sync_out;
        end
    end

    // Measurement FSM: period counter and lock indication.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            locked <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    state <= ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt    <= CNT_ONE;
                        locked <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output register: load when free or being drained this cycle, else drop.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            period_out   <= '0;
            period_valid <= 1'b0;
            ovf          <= 1'b0;
            glitch       <= 1'b0;
            dropped      <= 1'b0;
        end else if (capture && (!period_valid || period_ready)) begin
            period_out   <= cnt;
            ovf          <= (cnt == CNT_MAX);
            glitch       <= (cnt < CNT_MIN);
            period_valid <= 1'b1;
        end else begin
            if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
            if (capture) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: square waves built from timed high/low pulses,
// expected periods derived from the pulse durations.
module tb_period_meter;

    localparam int CNT_W   = 6;
    localparam int MIN_P   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             sig_in;
    logic             enable;
    logic             period_ready;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             ovf;
    logic             glitch;
    logic             dropped;
    logic             locked;

    period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .MIN_PERIOD (MIN_P)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .enable      (enable),
        .period_out  (period_out),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .ovf         (ovf),
        .glitch      (glitch),
        .dropped     (dropped),
        .locked      (locked)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int p;
        int o;
        int g;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   armed = 0;
    bit   bp_mode = 0;
    int   dur = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference: each rise after arming reports the time since the last rise.
    function automatic void model_rise();
        exp_t e;
        if (armed) begin
            e.p = (dur >= SAT) ? SAT : dur;
            e.o = (dur >= SAT) ? 1 : 0;
            e.g = (e.p < MIN_P) ? 1 : 0;
            if (!(bp_mode && q.size() > 0)) q.push_back(e);
        end
        armed = 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        sig_in = 1'b1;
        model_rise();
        dur = hi + lo;
        tick(hi);
        sig_in = 1'b0;
        tick(lo);
    endtask

    // Consumer side: every valid result must equal the oldest expected one.
    always @(negedge clk_in) begin
        if (!reset && period_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", period_valid, 0);
            end else begin
                check("period_out", period_out, q[0].p);
                check("ovf", ovf, q[0].o);
                check("glitch", glitch, q[0].g);
                if (period_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int hi;
        int lo;
        reset        = 1'b1;
        sig_in       = 1'b0;
        enable       = 1'b0;
        period_ready = 1'b1;
        tick(3);
        check("rst_out", period_out, 0);
        check("rst_valid", period_valid, 0);
        check("rst_flags", {ovf, glitch, dropped, locked}, 0);
        reset = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(8);

        // Divider=3 source: 4 high, 4 low -> period 8.
        pulse(4, 4);
        check("locked_after_arm", locked, 0);
        for (int i = 0; i < 5; i++) pulse(4, 4);
        check("locked_div", locked, 1);

        // Capture coinciding with acceptance of a held result.
        period_ready = 1'b0;
        pulse(6, 6);
        check("held_valid", period_valid, 1);
        sig_in = 1'b1;
        model_rise();
        dur = 14;
        tick(2);
        period_ready = 1'b1;
        tick(1);
        check("overlap_valid", period_valid, 1);
        check("overlap_out", period_out, 12);
        check("overlap_dropped", dropped, 0);
        tick(4);
        sig_in = 1'b0;
        tick(7);

        // Glitch: toggling every cycle.
        for (int i = 0; i < 5; i++) pulse(1, 1);

        // Random periods.
        for (int i = 0; i < 12; i++) begin
            hi = int'($urandom_range(1, 15));
            lo = int'($urandom_range(1, 15));
            pulse(hi, lo);
        end

        // Saturation: held low 100 cycles.
        pulse(1, 100);
        pulse(5, 5);
        pulse(5, 5);
        pulse(10, 10);

        // Backpressure over three periods of 20.
        period_ready = 1'b0;
        bp_mode = 1'b1;
        pulse(10, 10);
        check("bp_dropped_first", dropped, 0);
        pulse(10, 10);
        check("bp_dropped", dropped, 1);
        pulse(10, 10);
        bp_mode = 1'b0;
        period_ready = 1'b1;
        pulse(10, 10);
        pulse(10, 10);
        check("dropped_sticky", dropped, 1);

        // Enable drop 5 cycles into a period of 30.
        sig_in = 1'b1;
        model_rise();
        tick(5);
        enable = 1'b0;
        armed = 1'b0;
        tick(2);
        check("locked_dis", locked, 0);
        tick(8);
        sig_in = 1'b0;
        tick(15);
        enable = 1'b1;
        tick(5);
        pulse(15, 15);
        check("locked_rearm", locked, 0);
        pulse(15, 15);
        check("locked_relock", locked, 1);
        pulse(15, 15);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        check("drain", q.size(), 0);

        // Asynchronous reset between clock edges.
        sig_in = 1'b1;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out", period_out, 0);
        check("arst_valid", period_valid, 0);
        check("arst_flags", {ovf, glitch, dropped, locked}, 0);
        q.delete();
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
